// File: rtl/risc_pkg.sv
// Shared definitions for the VERI_RISC boot loader: opcodes, loader states and memory sizing.
package risc_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CPU_RST = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4
    } loader_state_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    localparam int DEFAULT_AW    = 5;
    localparam int DEFAULT_DEPTH = depth_of(DEFAULT_AW);

endpackage

// File: rtl/risc_cycle_counter.sv
// Saturating up-counter with synchronous clear; hit_max flags the enabled clock whose
// increment lands exactly on MAX.
module risc_cycle_counter #(
    parameter int CW  = 16,
    parameter int MAX = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          hit_max
);

    localparam logic [CW-1:0] MAX_V  = CW'(MAX);
    localparam logic [CW-1:0] MAX_M1 = CW'(MAX - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX_V)) begin
            count <= count + CW'(1);
        end
    end

    assign hit_max = en && (count == MAX_M1);

endmodule

// File: rtl/risc_boot_loader.sv
// Loads a byte image into the VERI_RISC memory while holding the core in reset,
// then releases it and measures run length until halt or timeout.
module risc_boot_loader
    import risc_pkg::*;
#(
    parameter int AW         = 5,
    parameter int CW         = 16,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_wr,
    output logic          cpu_rst,
    input  logic          cpu_halt,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          overflow,
    output logic [CW-1:0] run_cycles
);

    localparam int DEPTH   = depth_of(AW);
    localparam int ADDR_CW = $clog2(DEPTH) + 1;

    loader_state_t      state_q, state_d;
    logic [ADDR_CW-1:0] addr_q;
    logic               timeout_q, overflow_q;
    logic               start_ok, accept, set_ovf, set_tmo;
    logic               run_en, rst_en, rst_clr;
    logic               run_hit, rst_hit;
    logic [CW-1:0]      rst_count_unused;
    logic               wrapped;

    // Top bit of the address counter records that all DEPTH slots are already used.
    assign wrapped = addr_q[ADDR_CW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        accept   = 1'b0;
        set_ovf  = 1'b0;
        set_tmo  = 1'b0;
        run_en   = 1'b0;
        rst_en   = 1'b0;
        rst_clr  = (state_q != CPU_RST);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    accept = 1'b1;
                    if (wrapped) begin
                        set_ovf = 1'b1;
                        state_d = DONE;
                    end else if (ld_last) begin
                        state_d = CPU_RST;
                    end
                end
            end
            CPU_RST: begin
                rst_en = 1'b1;
                if (rst_hit) state_d = RUN;
            end
            RUN: begin
                // A halt seen on the same clock as the final count takes priority over timeout.
                if (cpu_halt) begin
                    state_d = DONE;
                end else begin
                    run_en = 1'b1;
                    if (run_hit) begin
                        set_tmo = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (start_ok) begin
            addr_q     <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (accept)  addr_q     <= addr_q + ADDR_CW'(1);
            if (set_tmo) timeout_q  <= 1'b1;
            if (set_ovf) overflow_q <= 1'b1;
        end
    end

    risc_cycle_counter #(.CW(CW), .MAX(MAX_CYCLES)) u_run_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_ok),
        .en      (run_en),
        .count   (run_cycles),
        .hit_max (run_hit)
    );

    risc_cycle_counter #(.CW(CW), .MAX(RST_CYCLES)) u_rst_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (rst_clr),
        .en      (rst_en),
        .count   (rst_count_unused),
        .hit_max (rst_hit)
    );

    // An overflowed image is never run, so the core stays in reset through DONE.
    assign cpu_rst   = (state_q == IDLE) || (state_q == LOAD) || (state_q == CPU_RST)
                     || ((state_q == DONE) && overflow_q);
    assign ld_ready  = (state_q == LOAD);
    assign mem_wr    = accept && !wrapped;
    assign mem_addr  = addr_q[AW-1:0];
    assign mem_wdata = ld_data;
    assign busy      = (state_q == LOAD) || (state_q == CPU_RST) || (state_q == RUN);
    assign done      = (state_q == DONE);
    assign timeout   = timeout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_risc_boot_loader.sv
// Scoreboard bench: pairs the loader with a small VERI_RISC behavioural core and checks
// memory writes, reset release timing and the DONE-state results.
module tb_risc_boot_loader;
    import risc_pkg::*;

    localparam int AW         = 5;
    localparam int CW         = 16;
    localparam int RST_CYCLES = 2;
    localparam int MAX_CYCLES = 100;

    typedef struct packed {
        logic [CW-1:0] run;
        logic          tmo;
        logic          ovf;
        logic          crst;
    } done_rec_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          ld_valid;
    logic          ld_ready;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_wr;
    logic          cpu_rst;
    logic          cpu_halt;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          overflow;
    logic [CW-1:0] run_cycles;

    int checks = 0;
    int errors = 0;

    logic [AW+7:0] exp_wr[$];
    done_rec_t     exp_done[$];
    logic [7:0]    img[$];
    logic          done_prev;

    risc_boot_loader #(
        .AW(AW), .CW(CW), .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .cpu_rst    (cpu_rst),
        .cpu_halt   (cpu_halt),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .overflow   (overflow),
        .run_cycles (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural core: 8 phases per instruction, fetch in phase 1, halt shows in phase 4.
    logic [7:0] cmem [32];
    logic [2:0] phase;
    logic [4:0] pc;
    logic [7:0] acc;
    logic [7:0] ir;

    initial begin
        for (int i = 0; i < 32; i++) cmem[i] = 8'h00;
    end

    assign cpu_halt = !cpu_rst && (phase == 3'd4) && (ir[7:5] == HLT);

    always @(posedge clk) begin
        if (mem_wr) cmem[mem_addr] <= mem_wdata;
        if (cpu_rst) begin
            phase <= 3'd0;
            pc    <= 5'd0;
            acc   <= 8'd0;
            ir    <= 8'd0;
        end else if (!cpu_halt) begin
            phase <= phase + 3'd1;
            if (phase == 3'd1) ir <= cmem[pc];
            if (phase == 3'd7) begin
                case (ir[7:5])
                    SKZ:     pc <= pc + ((acc == 8'd0) ? 5'd2 : 5'd1);
                    ADD:     begin acc <= acc + cmem[ir[4:0]]; pc <= pc + 5'd1; end
                    AND:     begin acc <= acc & cmem[ir[4:0]]; pc <= pc + 5'd1; end
                    XOR:     begin acc <= acc ^ cmem[ir[4:0]]; pc <= pc + 5'd1; end
                    LDA:     begin acc <= cmem[ir[4:0]];       pc <= pc + 5'd1; end
                    STO:     begin cmem[ir[4:0]] <= acc;       pc <= pc + 5'd1; end
                    JMP:     pc <= ir[4:0];
                    default: pc <= pc;
                endcase
            end
        end
    end

    function automatic logic [7:0] instr(input opcode_t op, input logic [4:0] a);
        return {op, a};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes memory or enters DONE.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%0h expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    checkOutput("mem_write", 32'({mem_addr, mem_wdata}), 32'(exp_wr.pop_front()));
                end
            end
            if (done && !done_prev) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    checkOutput("done_record", 32'({run_cycles, timeout, overflow, cpu_rst}),
                                32'(exp_done.pop_front()));
                    checkOutput("busy_in_done", 32'(busy), 32'd0);
                end
            end
        end
        done_prev <= done;
    end

    task automatic applyStimulus(input bit gaps, input bit send_last, input bit wait_done,
                                 input int exp_run, input bit exp_tmo, input bit exp_ovf);
        int n;
        for (int i = 0; i < img.size(); i++) begin
            if (i < 32) exp_wr.push_back({5'(i), img[i]});
        end
        if (wait_done) exp_done.push_back('{run: CW'(exp_run), tmo: exp_tmo, ovf: exp_ovf, crst: exp_ovf});
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        checkOutput("ld_ready_after_start", 32'(ld_ready), 32'd1);
        for (int i = 0; i < img.size(); i++) begin
            if (gaps && i > 0) begin
                ld_valid = 1'b0;
                @(posedge clk) #1;
            end
            ld_valid = 1'b1;
            ld_data  = img[i];
            ld_last  = send_last && (i == img.size() - 1);
            @(posedge clk) #1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (send_last) begin
            n = 1;
            while (cpu_rst && n < 50) begin
                @(posedge clk) #1;
                n++;
            end
            checkOutput("cpu_rst_release_clks", 32'(n), 32'(RST_CYCLES + 1));
        end
        if (wait_done) begin
            n = 0;
            while (!done && n < 500) begin
                @(posedge clk) #1;
                n++;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("[TB] FAIL done_wait: got no done after %0d clks expected done", n);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        ld_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_cpu_rst",    32'(cpu_rst),    32'd1);
        checkOutput("reset_ld_ready",   32'(ld_ready),   32'd0);
        checkOutput("reset_mem_wr",     32'(mem_wr),     32'd0);
        checkOutput("reset_mem_addr",   32'(mem_addr),   32'd0);
        checkOutput("reset_done",       32'(done),       32'd0);
        checkOutput("reset_timeout",    32'(timeout),    32'd0);
        checkOutput("reset_overflow",   32'(overflow),   32'd0);
        checkOutput("reset_run_cycles", 32'(run_cycles), 32'd0);
        checkOutput("reset_busy",       32'(busy),       32'd0);
        @(posedge clk) #1 rst_n = 1'b1;

        $display("[TB] ld_valid while IDLE must not write");
        ld_valid = 1'b1;
        ld_data  = 8'hFF;
        repeat (2) @(posedge clk);
        #1 ld_valid = 1'b0;
        checkOutput("idle_stays_idle", 32'(busy), 32'd0);

        $display("[TB] test 1: single HLT");
        img = '{instr(HLT, 5'd0)};
        applyStimulus(1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0);

        $display("[TB] test 2: JMP 2, JMP 2, HLT");
        img = '{instr(JMP, 5'd2), instr(JMP, 5'd2), instr(HLT, 5'd0)};
        applyStimulus(1'b0, 1'b1, 1'b1, 12, 1'b0, 1'b0);

        $display("[TB] test 3: gapped stream, LDA/SKZ/HLT");
        img = '{instr(LDA, 5'd5), instr(SKZ, 5'd0), instr(HLT, 5'd0),
                instr(JMP, 5'd4), instr(HLT, 5'd0), 8'd1};
        applyStimulus(1'b1, 1'b1, 1'b1, 20, 1'b0, 1'b0);

        $display("[TB] test 4: JMP 0 runs into timeout");
        img = '{instr(JMP, 5'd0)};
        applyStimulus(1'b0, 1'b1, 1'b1, MAX_CYCLES, 1'b1, 1'b0);

        $display("[TB] test 5: 33-byte image without last");
        img.delete();
        for (int i = 0; i < 33; i++) img.push_back(8'(i) ^ 8'h5A);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);

        $display("[TB] test 6: reset during RUN, then reload");
        img = '{instr(JMP, 5'd0)};
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_cpu_rst",    32'(cpu_rst),    32'd1);
        checkOutput("abort_busy",       32'(busy),       32'd0);
        checkOutput("abort_run_cycles", 32'(run_cycles), 32'd0);
        checkOutput("abort_done",       32'(done),       32'd0);
        checkOutput("abort_ld_ready",   32'(ld_ready),   32'd0);
        @(posedge clk) #1 rst_n = 1'b1;
        img = '{instr(HLT, 5'd0)};
        applyStimulus(1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        checkOutput("write_queue_drained", 32'(exp_wr.size()),   32'd0);
        checkOutput("done_queue_drained",  32'(exp_done.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
